imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate generator.
- Decodes the RISC-V instruction format and produces:
  - the XLEN-wide sign/zero-extended immediate,
  - the PC-relative target,
  - a format code and an illegal flag.
- Output is registered behind a valid/ready handshake with optional skid buffering and flush.
- Sits between instruction fetch/IF-ID and the decode/execute register file read.

---
 rtl/imm_gen_pipe.sv | 92 +++++++++
 tb/tb_imm_gen_pipe.sv | 137 +++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate/target generator with valid/ready handshake, optional skid entry and flush
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int PW = 2*XLEN + 4;
  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_Z = 3'd6;
  logic [2:0]       f3;
  logic [XLEN-1:0]  imm_c;
  logic [2:0]       fmt_c;
  logic             ill_c;
  logic [PW-1:0]    pay_c, out_pay_q, out_pay_d, sk_pay_q, sk_pay_d;
  logic             out_valid_q, out_valid_d, sk_valid_q, sk_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_free, acc;
  assign f3 = in_inst[14:12];
  always_comb begin
    imm_c = '0;
    fmt_c = F_NONE;
    ill_c = 1'b0;
    case (in_inst[6:0])
      7'b0000011, 7'b0010011: begin fmt_c = F_I; imm_c = XLEN'($signed(in_inst[31:20])); end
      7'b1100111: if (f3 == 3'b000) begin fmt_c = F_I; imm_c = XLEN'($signed(in_inst[31:20])); end else ill_c = 1'b1;
      7'b0011011: if (XLEN == 64) begin fmt_c = F_I; imm_c = XLEN'($signed(in_inst[31:20])); end else ill_c = 1'b1;
      7'b0100011: begin fmt_c = F_S; imm_c = XLEN'($signed({in_inst[31:25], in_inst[11:7]})); end
      7'b1100011: begin fmt_c = F_B; imm_c = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0})); end
      7'b0110111, 7'b0010111: begin fmt_c = F_U; imm_c = XLEN'($signed({in_inst[31:12], 12'b0})); end
      7'b1101111: begin fmt_c = F_J; imm_c = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0})); end
      7'b1110011: if (f3 >= 3'b101) begin fmt_c = F_Z; imm_c = XLEN'(in_inst[19:15]); end
      7'b0110011, 7'b0111011: begin end
      default: ill_c = 1'b1;
    endcase
  end
  assign pay_c    = {ill_c, fmt_c, imm_c, in_pc + imm_c};
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (SKID != 0) ? !sk_valid_q : out_free;
  assign acc      = in_valid && in_ready;
  // skid entry always drains ahead of new input; acc cannot coincide with a full skid
  always_comb begin
    out_valid_d = out_valid_q;
    out_pay_d   = out_pay_q;
    sk_valid_d  = sk_valid_q;
    sk_pay_d    = sk_pay_q;
    if (out_free) begin
      out_valid_d = sk_valid_q || acc;
      out_pay_d   = sk_valid_q ? sk_pay_q : (acc ? pay_c : out_pay_q);
      sk_valid_d  = 1'b0;
    end else if (acc) begin
      sk_valid_d = 1'b1;
      sk_pay_d   = pay_c;
    end
    if (flush) begin
      out_valid_d = 1'b0;
      sk_valid_d  = 1'b0;
    end
    cnt_d = (acc && ill_c && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pay_q   <= '0;
      sk_valid_q  <= 1'b0;
      sk_pay_q    <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pay_q   <= out_pay_d;
      sk_valid_q  <= sk_valid_d;
      sk_pay_q    <= sk_pay_d;
      cnt_q       <= cnt_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign illegal_cnt = cnt_q;
  assign {out_illegal, out_fmt, out_imm, out_target} = out_pay_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks on three configurations (32-bit skid, 32-bit single stage, 64-bit skid)
module tb_imm_gen_pipe;
  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
  logic [31:0] inst = '0;
  logic [63:0] pc = '0;
  logic        va = 1'b0, ra = 1'b1, vb = 1'b0, rb = 1'b1, vc = 1'b0, rc = 1'b1;
  logic        rdy_a, ov_a, ill_a, rdy_b, ov_b, ill_b, rdy_c, ov_c, ill_c;
  logic [31:0] imm_a, tgt_a, imm_b, tgt_b;
  logic [63:0] imm_c, tgt_c;
  logic [2:0]  fmt_a, fmt_b, fmt_c;
  logic [1:0]  cnt_a;
  logic [15:0] cnt_b, cnt_c;
  int errs = 0, checks = 0;
  imm_gen_pipe #(.XLEN(32), .SKID(1), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(rdy_a), .in_inst(inst), .in_pc(pc[31:0]),
    .flush(flush), .out_valid(ov_a), .out_ready(ra), .out_imm(imm_a), .out_fmt(fmt_a),
    .out_target(tgt_a), .out_illegal(ill_a), .illegal_cnt(cnt_a));
  imm_gen_pipe #(.XLEN(32), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rdy_b), .in_inst(inst), .in_pc(pc[31:0]),
    .flush(flush), .out_valid(ov_b), .out_ready(rb), .out_imm(imm_b), .out_fmt(fmt_b),
    .out_target(tgt_b), .out_illegal(ill_b), .illegal_cnt(cnt_b));
  imm_gen_pipe #(.XLEN(64), .SKID(1), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_ready(rdy_c), .in_inst(inst), .in_pc(pc),
    .flush(flush), .out_valid(ov_c), .out_ready(rc), .out_imm(imm_c), .out_fmt(fmt_c),
    .out_target(tgt_c), .out_illegal(ill_c), .illegal_cnt(cnt_c));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [31:0] ill_inst [5] = '{32'h0, 32'h1B, 32'h0, 32'h0, 32'h0};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ov", ov_a, 0); chk("rst_imm", imm_a, 0); chk("rst_fmt", fmt_a, 0);
    chk("rst_tgt", tgt_a, 0); chk("rst_ill", ill_a, 0); chk("rst_cnt", cnt_a, 0);
    chk("rst_rdy_a", rdy_a, 1); chk("rst_rdy_b", rdy_b, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); inst = 32'hFFF00093; pc = 64'h0; va = 1'b1;
    @(negedge clk);
    chk("addi_ov", ov_a, 1); chk("addi_fmt", fmt_a, 1); chk("addi_imm", imm_a, 32'hFFFFFFFF);
    chk("addi_tgt", tgt_a, 32'hFFFFFFFF); chk("addi_ill", ill_a, 0);
    inst = 32'hFE112E23;
    @(negedge clk);
    chk("sw_fmt", fmt_a, 2); chk("sw_imm", imm_a, 32'hFFFFFFFC);
    inst = 32'hFE000CE3; pc = 64'h100;
    @(negedge clk);
    chk("beq_fmt", fmt_a, 3); chk("beq_imm", imm_a, 32'hFFFFFFF8); chk("beq_tgt", tgt_a, 32'hF8);
    va = 1'b0;
    @(negedge clk);
    chk("drain_ov", ov_a, 0);
    inst = 32'h800000B7; pc = 64'h0; vc = 1'b1;
    @(negedge clk);
    chk("lui_fmt", fmt_c, 4); chk("lui_imm", imm_c, 64'hFFFFFFFF80000000); chk("lui_tgt", tgt_c, 64'hFFFFFFFF80000000);
    inst = 32'h0010009B;
    @(negedge clk);
    chk("addiw_fmt", fmt_c, 1); chk("addiw_imm", imm_c, 1); chk("addiw_ill", ill_c, 0);
    inst = 32'h000FD073; pc = 64'h10;
    @(negedge clk);
    chk("csri_fmt", fmt_c, 6); chk("csri_imm", imm_c, 31); chk("csri_tgt", tgt_c, 64'h2F);
    vc = 1'b0;
    ra = 1'b0; inst = 32'h0040006F; pc = 64'h1000; va = 1'b1;
    @(negedge clk);
    chk("jal_ov", ov_a, 1); chk("jal_rdy1", rdy_a, 1); chk("jal_fmt", fmt_a, 5);
    chk("jal_imm", imm_a, 4); chk("jal_tgt", tgt_a, 32'h1004);
    inst = 32'hFFF00093; pc = 64'h0;
    @(negedge clk);
    chk("skid_rdy0", rdy_a, 0); chk("hold_imm1", imm_a, 4); chk("hold_tgt1", tgt_a, 32'h1004);
    inst = 32'hFE000CE3; pc = 64'h100;
    @(negedge clk);
    chk("skid_rdy0b", rdy_a, 0); chk("hold_imm2", imm_a, 4); chk("hold_ov", ov_a, 1);
    ra = 1'b1;
    @(negedge clk);
    chk("ord2_imm", imm_a, 32'hFFFFFFFF); chk("ord2_fmt", fmt_a, 1); chk("ord2_rdy", rdy_a, 1);
    @(negedge clk);
    chk("ord3_imm", imm_a, 32'hFFFFFFF8); chk("ord3_fmt", fmt_a, 3); chk("ord3_tgt", tgt_a, 32'hF8);
    va = 1'b0;
    @(negedge clk);
    chk("ord_done", ov_a, 0);
    rb = 1'b0; inst = 32'h0040006F; pc = 64'h1000; vb = 1'b1;
    @(negedge clk);
    chk("s0_ov", ov_b, 1); chk("s0_rdy", rdy_b, 0); chk("s0_imm", imm_b, 4);
    inst = 32'hFFF00093; pc = 64'h0;
    @(negedge clk);
    chk("s0_rdy_stall", rdy_b, 0); chk("s0_hold", imm_b, 4);
    rb = 1'b1;
    #1 chk("s0_rdy_comb", rdy_b, 1);
    @(negedge clk);
    chk("s0_b2_imm", imm_b, 32'hFFFFFFFF); chk("s0_b2_fmt", fmt_b, 1);
    vb = 1'b0;
    @(negedge clk);
    chk("s0_done", ov_b, 0);
    va = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst = ill_inst[i];
      @(negedge clk);
      chk("ill_flag", ill_a, 1); chk("ill_fmt", fmt_a, 0); chk("ill_imm", imm_a, 0);
      chk("ill_cnt", cnt_a, cnt_exp[i]);
    end
    va = 1'b0;
    @(negedge clk);
    ra = 1'b0; inst = 32'hFFF00093; pc = 64'h0; va = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("fl_full", rdy_a, 0);
    flush = 1'b1; inst = 32'h0;
    @(negedge clk);
    flush = 1'b0; va = 1'b0;
    chk("fl_ov", ov_a, 0); chk("fl_rdy", rdy_a, 1);
    ra = 1'b1;
    @(negedge clk);
    chk("fl_nothing", ov_a, 0);
    flush = 1'b1; inst = 32'h0; vb = 1'b1;
    @(negedge clk);
    flush = 1'b0; vb = 1'b0;
    chk("fl_b_ov", ov_b, 0); chk("fl_b_cnt", cnt_b, 1);
    ra = 1'b0; inst = 32'hFFF00093; va = 1'b1;
    @(negedge clk);
    chk("mr_ov", ov_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ov0", ov_a, 0); chk("mr_imm0", imm_a, 0); chk("mr_tgt0", tgt_a, 0);
    chk("mr_fmt0", fmt_a, 0); chk("mr_cnt0", cnt_a, 0); chk("mr_rdy", rdy_a, 1);
    @(negedge clk);
    rst_n = 1'b1; ra = 1'b1; inst = 32'hFE112E23; pc = 64'h0;
    @(negedge clk);
    chk("post_ov", ov_a, 1); chk("post_fmt", fmt_a, 2); chk("post_imm", imm_a, 32'hFFFFFFFC);
    va = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
